stopwatch_sequencer: RTL and testbench

//  Run/clear/lap controller for the stopwatch datapath. Conditions the raw start_stop,
//  lap_btn and reset_btn inputs (2-flop sync + debounce + press detect) and sequences the
//  BCD counter (run, clr) and the display mux (hold).

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_sequencer_btn_conditioner.sv | 44 ++++
 rtl/stopwatch_sequencer.sv | 104 ++++++++++
 tb/tb_stopwatch_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch run/clear/lap sequencer.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StLap   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      EvNone,
      EvReset,
      EvStart,
      EvLap
   } event_e;

   localparam int unsigned DebounceCyclesDefault = 1_000_000;

   // Same-cycle presses: reset beats start, start beats lap; losers are dropped.
   function automatic event_e resolve_press(input logic reset_p, input logic start_p,
                                            input logic lap_p);
      if (reset_p) return EvReset;
      if (start_p) return EvStart;
      if (lap_p)   return EvLap;
      return EvNone;
   endfunction

endpackage

// File: rtl/stopwatch_sequencer_btn_conditioner.sv
// Raw button conditioning: 2-flop sync, stability debounce, registered one-clk press pulse.
module btn_conditioner
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
   parameter int unsigned DB_W            = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   logic            sync1_q, sync2_q;
   logic            db_q, db_prev_q;
   logic [DB_W-1:0] cnt_q;

   // Counter only runs while the synced level disagrees with the accepted level;
   // any bounce back to the accepted level restarts the stability window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         cnt_q     <= '0;
         press     <= 1'b0;
      end else begin
         sync1_q   <= btn;
         sync2_q   <= sync1_q;
         db_prev_q <= db_q;
         press     <= db_q & ~db_prev_q;
         if (sync2_q == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_q  <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + DB_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control: conditions the three buttons, resolves priority and sequences
// the counter enable/clear, display hold and lap counter.
module stopwatch_sequencer
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
   parameter int unsigned DB_W            = 20,
   parameter int unsigned LAP_W           = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_stop,
   input  logic             lap_btn,
   input  logic             reset_btn,
   output logic             run,
   output logic             clr,
   output logic             hold,
   output logic             lap_capture,
   output logic [LAP_W-1:0] lap_count,
   output logic [1:0]       state
);

   logic   start_p, lap_p, reset_p;
   logic   take_lap;
   event_e ev;
   state_e state_q, state_d;

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_start (
      .clk   (clk),
      .reset (reset),
      .btn   (start_stop),
      .press (start_p)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_lap (
      .clk   (clk),
      .reset (reset),
      .btn   (lap_btn),
      .press (lap_p)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_reset (
      .clk   (clk),
      .reset (reset),
      .btn   (reset_btn),
      .press (reset_p)
   );

   assign ev    = resolve_press(reset_p, start_p, lap_p);
   assign state = state_q;

   always_comb begin
      state_d  = state_q;
      take_lap = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ev == EvStart) state_d = StRun;
         end
         StRun: begin
            if (ev == EvReset) begin
               state_d = StIdle;
            end else if (ev == EvStart) begin
               state_d = StPause;
            end else if (ev == EvLap) begin
               state_d  = StLap;
               take_lap = 1'b1;
            end
         end
         StLap: begin
            if (ev == EvReset)      state_d = StIdle;
            else if (ev == EvStart) state_d = StPause;
            else if (ev == EvLap)   state_d = StRun;
         end
         StPause: begin
            if (ev == EvReset)      state_d = StIdle;
            else if (ev == EvStart) state_d = StRun;
         end
      endcase
   end

   // Outputs decode from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         run         <= 1'b0;
         clr         <= 1'b1;
         hold        <= 1'b0;
         lap_capture <= 1'b0;
         lap_count   <= '0;
      end else begin
         state_q     <= state_d;
         run         <= (state_d == StRun) || (state_d == StLap);
         clr         <= (state_d == StIdle);
         hold        <= (state_d == StLap);
         lap_capture <= take_lap;
         if (state_d == StIdle) begin
            lap_count <= '0;
         end else if (take_lap && (lap_count != '1)) begin
            lap_count <= lap_count + LAP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Scoreboard bench for stopwatch_sequencer with a short debounce window.
module tb_stopwatch_sequencer;

   localparam int unsigned Deb = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start_stop = 1'b0;
   logic       lap_btn = 1'b0;
   logic       reset_btn = 1'b0;
   logic       run, clr, hold, lap_capture;
   logic [3:0] lap_count;
   logic [1:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   bit watch_pause = 1'b0;
   bit pause_seen  = 1'b0;

   typedef struct packed {
      logic [1:0] st;
      logic       run;
      logic       clr;
      logic       hold;
      logic       cap;
      logic [3:0] lc;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   stopwatch_sequencer #(.DEBOUNCE_CYCLES(Deb), .DB_W(20), .LAP_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_stop  (start_stop),
      .lap_btn     (lap_btn),
      .reset_btn   (reset_btn),
      .run         (run),
      .clr         (clr),
      .hold        (hold),
      .lap_capture (lap_capture),
      .lap_count   (lap_count),
      .state       (state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (watch_pause && state == 2'd2) pause_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", tag, got, exp);
   endtask

   task automatic expect_out(input string tag, input logic [1:0] st, input logic r,
                             input logic c, input logic h, input logic cap,
                             input logic [3:0] lc);
      exp_t e;
      e.st = st; e.run = r; e.clr = c; e.hold = h; e.cap = cap; e.lc = lc;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic compare_out();
      exp_t  e;
      string t;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".state"}, 32'(state), 32'(e.st));
      check({t, ".run"}, 32'(run), 32'(e.run));
      check({t, ".clr"}, 32'(clr), 32'(e.clr));
      check({t, ".hold"}, 32'(hold), 32'(e.hold));
      check({t, ".cap"}, 32'(lap_capture), 32'(e.cap));
      check({t, ".lap_count"}, 32'(lap_count), 32'(e.lc));
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: reset_btn = v;
         1: start_stop = v;
         default: lap_btn = v;
      endcase
   endtask

   // Hold a button 10 clk; outputs must move exactly 2+Deb+1+1 clk after the raw edge.
   task automatic press_and_check(input int b, input logic [1:0] old_st, input string tag);
      set_btn(b, 1'b1);
      repeat (2 + Deb + 1) @(negedge clk);
      check({tag, ".early"}, 32'(state), 32'(old_st));
      @(negedge clk);
      compare_out();
      @(negedge clk);
      check({tag, ".cap_width"}, 32'(lap_capture), 32'd0);
      @(negedge clk);
      set_btn(b, 1'b0);
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int lc;

      // 1. reset values, then start
      repeat (3) @(negedge clk);
      expect_out("in_reset", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      compare_out();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      expect_out("post_reset", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      compare_out();
      expect_out("start", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      press_and_check(1, 2'd0, "start");

      // 2. short pulse and bounce are ignored, then one stable press
      start_stop = 1'b1;
      repeat (3) @(negedge clk);
      start_stop = 1'b0;
      repeat (12) @(negedge clk);
      expect_out("glitch", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      compare_out();
      for (int i = 0; i < 10; i++) begin
         start_stop = ~start_stop;
         repeat (2) @(negedge clk);
      end
      start_stop = 1'b0;
      repeat (12) @(negedge clk);
      expect_out("bounce", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      compare_out();
      expect_out("stable_pause", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      press_and_check(1, 2'd1, "stable_pause");
      expect_out("resume", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      press_and_check(1, 2'd2, "resume");

      // 3. lap in / lap out
      expect_out("lap1", 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1);
      press_and_check(2, 2'd1, "lap1");
      expect_out("lap1_out", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      press_and_check(2, 2'd3, "lap1_out");

      // 4. pause, lap ignored, resume, reset_btn
      expect_out("pause", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
      press_and_check(1, 2'd1, "pause");
      expect_out("pause_lap", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
      press_and_check(2, 2'd2, "pause_lap");
      expect_out("unpause", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      press_and_check(1, 2'd2, "unpause");
      expect_out("rst_btn", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      press_and_check(0, 2'd1, "rst_btn");

      // 5. start and reset_btn together in RUN: reset wins
      expect_out("start2", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      press_and_check(1, 2'd0, "start2");
      watch_pause = 1'b1;
      start_stop  = 1'b1;
      reset_btn   = 1'b1;
      repeat (2 + Deb + 2) @(negedge clk);
      expect_out("prio", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      compare_out();
      start_stop = 1'b0;
      reset_btn  = 1'b0;
      repeat (12) @(negedge clk);
      watch_pause = 1'b0;
      check("prio.no_pause", 32'(pause_seen), 32'd0);

      // 6. lap counter saturation
      expect_out("start3", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      press_and_check(1, 2'd0, "start3");
      for (int i = 0; i < 17; i++) begin
         lc = (i + 1 > 15) ? 15 : i + 1;
         expect_out($sformatf("lap_in%0d", i), 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'(lc));
         press_and_check(2, 2'd1, $sformatf("lap_in%0d", i));
         expect_out($sformatf("lap_out%0d", i), 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'(lc));
         press_and_check(2, 2'd3, $sformatf("lap_out%0d", i));
      end

      // async reset mid-debounce of start
      start_stop = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      expect_out("async_rst", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      compare_out();
      @(negedge clk);
      start_stop = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      expect_out("after_rst", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      compare_out();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
